// File: rtl/fetch_pkg.sv
//----------------------------------------------------------------------------
// fetch_pkg
// Shared constants, state encoding and buffer entry type for the fetch unit.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam logic [5:0]  OPC_J            = 6'b000010;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] STOP = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
//----------------------------------------------------------------------------
// fetch_buffer
// Two-entry FIFO of {pc, instr}; flush beats push/pop, head holds when empty.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_din,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  localparam fetch_entry_t c_empty_entry = '{pc: 32'h0, instr: NOP_WORD};

  fetch_entry_t r_head;
  fetch_entry_t r_tail;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_head  <= c_empty_entry;
      r_tail  <= c_empty_entry;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_din;
          else                 r_tail <= i_din;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          // with one entry the head register keeps its value as the held output
          if (r_count == 2'd2) r_head <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_din;
          end else begin
            r_head <= r_tail;
            r_tail <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_head;

endmodule

`default_nettype wire

// File: rtl/fetch_controller.sv
//----------------------------------------------------------------------------
// fetch_controller
// PC sequencing and instruction buffering with redirect flush.
// Optional self-jump halt detection: define HALT_DETECT_EN.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          IMEM_WORDS = 178,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  output logic        FetchValid,
  output logic [31:0] FetchInstruction,
  output logic [31:0] FetchPC,
  input  logic        DecodeReady,
  output logic [1:0]  BufCount,
  output logic        Stopped,
  output logic        Halted
);

  localparam logic [1:0]  c_depth = 2'(BUF_DEPTH);
  localparam logic [31:0] c_limit = 32'(IMEM_WORDS * 4);

  logic [1:0]   r_state;
  logic [31:0]  r_pc;
  logic [1:0]   w_count;
  fetch_entry_t w_head;
  fetch_entry_t w_din;
  logic         w_in_range;
  logic         w_pop;
  logic         w_push;
  logic         w_self_jump;

  assign w_in_range = (r_pc < c_limit);
  assign w_pop      = FetchValid & DecodeReady & ~RedirectValid;
  assign w_push     = (r_state == RUN) & ~RedirectValid & w_in_range &
                      ((w_count < c_depth) | w_pop);
  assign w_din      = '{pc: r_pc, instr: ImemInstruction};

`ifdef HALT_DETECT_EN
  assign w_self_jump = (ImemInstruction[31:26] == OPC_J) &&
                       (ImemInstruction[25:0] == r_pc[27:2]);
`else
  assign w_self_jump = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc    <= RESET_PC;
      r_state <= RUN;
    end else if (RedirectValid) begin
      r_pc    <= RedirectTarget & ~32'h3;
      r_state <= RUN;
    end else begin
      if (w_push) r_pc <= r_pc + 32'd4;
      // the self-jump word is enqueued in the same cycle it triggers HALT
      if (r_state == RUN) begin
        if (!w_in_range)               r_state <= STOP;
        else if (w_push && w_self_jump) r_state <= HALT;
      end
    end
  end

  fetch_buffer u_buffer (
    .clk     (Clk),
    .rst     (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (RedirectValid),
    .i_din   (w_din),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign ImemAddress      = r_pc;
  assign BufCount         = w_count;
  assign FetchValid       = (w_count != 2'd0);
  assign FetchInstruction = w_head.instr;
  assign FetchPC          = w_head.pc;
  assign Stopped          = (r_state == STOP);

`ifdef HALT_DETECT_EN
  assign Halted = (r_state == HALT);
`else
  assign Halted = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_controller.sv
//----------------------------------------------------------------------------
// tb_fetch_controller
// Directed scenarios plus random traffic against a queue-based fetch model.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_controller;

  localparam int NWORDS = 178;
  localparam logic [31:0] LIMIT = 32'd712;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] ImemAddress;
  logic [31:0] ImemInstruction;
  logic        RedirectValid;
  logic [31:0] RedirectTarget;
  logic        FetchValid;
  logic [31:0] FetchInstruction;
  logic [31:0] FetchPC;
  logic        DecodeReady;
  logic [1:0]  BufCount;
  logic        Stopped;
  logic        Halted;

  logic [31:0] mem [NWORDS];
  int total = 0;
  int bad   = 0;

  // reference model state
  ent_t        q[$];
  logic [31:0] m_pc;
  logic        m_stopped;
  logic        m_halted;

  fetch_controller dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .ImemAddress      (ImemAddress),
    .ImemInstruction  (ImemInstruction),
    .RedirectValid    (RedirectValid),
    .RedirectTarget   (RedirectTarget),
    .FetchValid       (FetchValid),
    .FetchInstruction (FetchInstruction),
    .FetchPC          (FetchPC),
    .DecodeReady      (DecodeReady),
    .BufCount         (BufCount),
    .Stopped          (Stopped),
    .Halted           (Halted)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a < LIMIT) return mem[a[31:2]];
    return 32'hFFFF_0000 ^ a;
  endfunction

  always_comb ImemInstruction = imem_word(ImemAddress);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic redir, input logic [31:0] tgt,
                            input logic rdy);
    logic pop, push, running;
    logic [31:0] w;
    if (rst) begin
      q.delete();
      m_pc = 32'h0;
      m_stopped = 1'b0;
      m_halted = 1'b0;
    end else if (redir) begin
      q.delete();
      m_pc = {tgt[31:2], 2'b00};
      m_stopped = 1'b0;
      m_halted = 1'b0;
    end else begin
      running = !m_stopped && !m_halted;
      pop  = (q.size() != 0) && rdy;
      push = running && (m_pc < LIMIT) && (q.size() < 2 || pop);
      if (pop) void'(q.pop_front());
      if (running && m_pc >= LIMIT) m_stopped = 1'b1;
      if (push) begin
        w = imem_word(m_pc);
        q.push_back('{pc: m_pc, instr: w});
`ifdef HALT_DETECT_EN
        if (w[31:26] == 6'b000010 && {w[25:0], 2'b00} == {m_pc[27:0]}) m_halted = 1'b1;
`endif
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Called at posedge+1: drive, sample mid-cycle, advance the model, wait to next posedge+1.
  task automatic cycle(input logic rst, input logic redir, input logic [31:0] tgt,
                       input logic rdy);
    Reset = rst;
    RedirectValid = redir;
    RedirectTarget = tgt;
    DecodeReady = rdy;
    #3;
    check_eq("imem_addr", ImemAddress, m_pc);
    check_eq("valid", FetchValid, q.size() != 0);
    check_eq("count", BufCount, q.size());
    if (q.size() != 0) begin
      check_eq("head_pc", FetchPC, q[0].pc);
      check_eq("head_instr", FetchInstruction, q[0].instr);
    end
    check_eq("stopped", Stopped, m_stopped);
    check_eq("halted", Halted, m_halted);
    model_step(rst, redir, tgt, rdy);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      mem[i] = $urandom();
      if (mem[i][31:26] == 6'b000010) mem[i][31:26] = 6'b100011;
    end
    mem[0] = 32'h23BDFFFC;
    mem[8] = 32'h08000008;

    Reset = 1'b1;
    RedirectValid = 1'b0;
    RedirectTarget = 32'h0;
    DecodeReady = 1'b1;
    model_step(1'b1, 1'b0, 32'h0, 1'b1);
    @(posedge Clk);
    #1;

    // reset held, then release
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    check_eq("rst_instr", FetchInstruction, 32'h0);
    check_eq("rst_pc", FetchPC, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("first_valid", FetchValid, 1'b1);
    check_eq("first_instr", FetchInstruction, 32'h23BDFFFC);

    // decode stall fills the buffer
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("stall_addr", ImemAddress, 32'h8);
    check_eq("stall_count", BufCount, 2'd2);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // redirect while full
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_00A3, 1'b1);
    check_eq("redir_valid", FetchValid, 1'b0);
    check_eq("redir_count", BufCount, 2'd0);
    check_eq("redir_addr", ImemAddress, 32'hA0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("redir_head", FetchPC, 32'hA0);

    // run to the end of memory, then restart
    cycle(1'b0, 1'b1, 32'h40, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (180) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("end_stopped", Stopped, 1'b1);
    check_eq("end_addr", ImemAddress, LIMIT);
    cycle(1'b0, 1'b1, 32'h0, 1'b1);
    check_eq("restart_stopped", Stopped, 1'b0);

    // self-jump at 0x20
    cycle(1'b0, 1'b1, 32'h10, 1'b1);
    repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef HALT_DETECT_EN
    check_eq("halt_flag", Halted, 1'b1);
    check_eq("halt_addr", ImemAddress, 32'h24);
`endif
    cycle(1'b0, 1'b1, 32'h0, 1'b1);
    check_eq("unhalt", Halted, 1'b0);

    // reset beats redirect and pop
    repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 32'h100, 1'b1);
    check_eq("rr_addr", ImemAddress, 32'h0);
    check_eq("rr_count", BufCount, 2'd0);
    check_eq("rr_stopped", Stopped, 1'b0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic r, rd, dr;
      logic [31:0] t;
      r  = ($urandom_range(0, 49) == 0);
      rd = ($urandom_range(0, 15) == 0);
      dr = ($urandom_range(0, 9) < 7);
      t  = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 800));
      cycle(r, rd, t, dr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the instruction memory for the SAD pipeline: owns the PC, drives the instruction-memory word address, and buffers fetched words in a 2-entry queue for decode under a valid/ready handshake.
- Takes branch/jump redirects from the pipeline and flushes in-flight fetches.
- Instruction memory is combinational: the word appears in the same cycle as its address.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- IMEM_WORDS, 178, populated instruction words; fetch stops at byte address IMEM_WORDS*4.
- BUF_DEPTH, 2, instruction-buffer entries; fixed at 2, other values unsupported.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- ImemAddress  out  32  byte address to instruction memory (= PC register).
- ImemInstruction  in  32  instruction word at ImemAddress, same cycle.
- RedirectValid  in  1  branch/jump taken this cycle.
- RedirectTarget  in  32  new PC; bits [1:0] ignored (forced 0).
- FetchValid  out  1  buffer head valid.
- FetchInstruction  out  32  buffer head instruction.
- FetchPC  out  32  byte address of buffer head.
- DecodeReady  in  1  decode consumes head when FetchValid & DecodeReady.
- BufCount  out  2  occupied entries, 0..2.
- Stopped  out  1  fetch has run past IMEM_WORDS.
- Halted  out  1  self-jump detected; present only with HALT_DETECT_EN, otherwise tied 0.

Behaviour:
- Reset state:
  - PC = RESET_PC and ImemAddress = RESET_PC.
  - Buffer empty: FetchValid = 0, BufCount = 0.
  - FetchInstruction = 0, FetchPC = 0, Stopped = 0, Halted = 0, state RUN.
- States and transitions:
  - RUN: fetching. Goes to STOP when PC >= IMEM_WORDS*4; goes to HALT on self-jump (feature only).
  - STOP and HALT: PC holds, no pushes. Leave only on RedirectValid or Reset.
- Definitions:
  - pop = FetchValid & DecodeReady.
  - push = state==RUN & !RedirectValid & (BufCount<2 | pop).
- On push, the entry {PC, ImemInstruction} is enqueued and PC <= PC+4. PC wraps modulo 2^32; no error.
- Latency: the first entry is visible (FetchValid=1) one cycle after Reset deasserts. Sustained throughput is 1 instruction/cycle while DecodeReady=1.
- Full buffer (BufCount=2):
  - with pop: push and pop in the same cycle, count stays 2, order preserved;
  - without pop: PC holds and ImemAddress is stable.
- Empty buffer with pop impossible: FetchValid=0 means no pop.
- Redirect priority over everything except Reset:
  - flush all entries and ignore pop (the decode handshake that cycle is discarded);
  - PC <= {RedirectTarget[31:2],2'b00};
  - state <= RUN, Stopped <= 0, Halted <= 0.
  - FetchValid = 0 in the next cycle. The first target entry is visible two cycles after the redirect.
- Reset mid-operation: Reset overrides redirect and pop; state returns to the reset values above in one cycle.
- Stopped = (state==STOP), registered. Entries already buffered still drain normally in STOP/HALT.
- FetchInstruction and FetchPC hold their last head values when FetchValid=0. The bench must not check them then.

Optional Feature:
- Macro: HALT_DETECT_EN.
- Defined:
  - A pushed word with opcode 6'b000010 and target field [25:0] == PC[27:2] (j-to-self) is enqueued normally.
  - The state then goes to HALT and Halted=1 from the next cycle. No further fetches until a redirect.
  - This removes the endless endloop/quit fetch traffic.
- Undefined: no detection; the self-jump is fetched repeatedly through ordinary redirects; Halted tied 0.

Decomposition:
- Shared package fetch_pkg:
  - OPC_J = 6'b000010;
  - NOP_WORD = 32'h0;
  - state encoding RUN=2'd0, STOP=2'd1, HALT=2'd2;
  - RESET_PC default.
- One sub-module, fetch_buffer: 2-entry FIFO of {pc[31:0], instr[31:0]}.
  - Inputs: push, pop, flush.
  - Outputs: count, head.
  - Flush has priority over push/pop.

Test Plan:
- Reset held 3 cycles, then released with DecodeReady=1 → ImemAddress 0,4,8,… on consecutive cycles; FetchPC 0 with instr 32'h23BDFFFC one cycle after release; one entry per cycle after that.
- DecodeReady=0 for 5 cycles from cycle 2 → BufCount reaches 2; ImemAddress frozen at 8; no entry lost or duplicated after DecodeReady returns to 1.
- RedirectValid with target 32'h0000_00A3 while BufCount=2 → next cycle FetchValid=0 and BufCount=0; ImemAddress=32'hA0; following cycle FetchPC=32'hA0.
- Fetch runs to address 712 (=178*4) → Stopped=1 and no pushes; buffered entries drain; redirect to 0 clears Stopped.
- HALT_DETECT_EN with instr 32'h08000008 fetched at PC 32'h20 → entry pushed, Halted=1 the next cycle, ImemAddress stays 32'h24; redirect to 0 clears Halted.
- Reset asserted in the same cycle as RedirectValid and pop → PC=RESET_PC, buffer empty, state RUN.
